// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, req/ack instruction-memory port and a one-entry fetch buffer.
// Optional performance counters are compiled in when IF_FETCH_PERF_EN is defined.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] Redirect_PC,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ack,
  input  logic [31:0] Imem_Data,
  output logic [31:0] PC_4,
  output logic [31:0] Inst,
  output logic        IF_Flush,
  output logic        IF_stall,
  output logic [31:0] PC
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] Perf_Fetch_Cnt,
  output logic [31:0] Perf_Stall_Cnt
`endif
);

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] target_pc;
  logic [31:0] buf_inst, buf_inst_next;
  logic [31:0] buf_pc4, buf_pc4_next;
  logic [31:0] drop_addr, drop_addr_next;
  logic        buf_valid, buf_valid_next;
  logic        req_pending, req_pending_next;
  logic        drain;
  logic        launch;
  logic        ack;

  // A new request may only start when the buffer will have room at the next edge.
  always_comb begin
    pc_plus4  = pc + 32'd4;
    target_pc = Redirect_PC & ~32'd3;
    drain     = buf_valid && !Stall && !Redirect;
    launch    = !Rst && (state == FETCH) && !req_pending && !Redirect &&
                (!buf_valid || drain);
    Imem_Req  = !Rst && ((state == DROP) || req_pending || launch);
    Imem_Addr = (state == DROP) ? drop_addr : pc;
    ack       = Imem_Ack && Imem_Req;
  end

  always_comb begin
    state_next       = state;
    pc_next          = pc;
    buf_valid_next   = buf_valid;
    buf_inst_next    = buf_inst;
    buf_pc4_next     = buf_pc4;
    drop_addr_next   = drop_addr;
    req_pending_next = req_pending;

    if (drain) begin
      buf_valid_next = 1'b0;
    end

    case (state)
      FETCH: begin
        if (Redirect) begin
          pc_next          = target_pc;
          buf_valid_next   = 1'b0;
          req_pending_next = 1'b0;
          // An outstanding request cannot be withdrawn; remember its address and eat the reply.
          if (Imem_Req && !ack) begin
            state_next     = DROP;
            drop_addr_next = pc;
          end
        end else if (ack) begin
          buf_valid_next   = 1'b1;
          buf_inst_next    = Imem_Data;
          buf_pc4_next     = pc_plus4;
          pc_next          = pc_plus4;
          req_pending_next = 1'b0;
        end else if (Imem_Req) begin
          req_pending_next = 1'b1;
        end
      end
      DROP: begin
        if (Redirect) begin
          pc_next        = target_pc;
          buf_valid_next = 1'b0;
        end
        if (ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_valid   <= 1'b0;
      buf_inst    <= NOP_INST;
      buf_pc4     <= 32'd0;
      drop_addr   <= 32'd0;
      req_pending <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      buf_valid   <= buf_valid_next;
      buf_inst    <= buf_inst_next;
      buf_pc4     <= buf_pc4_next;
      drop_addr   <= drop_addr_next;
      req_pending <= req_pending_next;
    end
  end

  always_comb begin
    Inst     = buf_valid ? buf_inst : NOP_INST;
    PC_4     = buf_pc4;
    IF_stall = Stall | !buf_valid;
    IF_Flush = Redirect;
    PC       = pc;
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // Only replies that actually land in the buffer count as fetches.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (ack && (state == FETCH) && !Redirect) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (IF_stall) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign Perf_Fetch_Cnt = fetch_cnt;
  assign Perf_Stall_Cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model with configurable wait states and a
// scoreboard of fetched words that must reach IF/ID in order.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Redirect;
  logic [31:0] Redirect_PC;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Data;
  logic [31:0] PC_4;
  logic [31:0] Inst;
  logic        IF_Flush;
  logic        IF_stall;
  logic [31:0] PC;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int pass_count  = 0;
  int total_count = 0;

  int wait_states;
  int wait_cnt;
  bit mem_manual;
  bit man_ack;

  logic [63:0] sb_q[$];
  logic [31:0] exp_pc;
  bit          drop_flag;
  bit          prev_out;
  logic [31:0] prev_addr;

  if_fetch_unit #(
    .RESET_PC(RESET_PC),
    .NOP_INST(NOP_INST)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .Redirect_PC(Redirect_PC),
    .Imem_Req   (Imem_Req),
    .Imem_Addr  (Imem_Addr),
    .Imem_Ack   (Imem_Ack),
    .Imem_Data  (Imem_Data),
    .PC_4       (PC_4),
    .Inst       (Inst),
    .IF_Flush   (IF_Flush),
    .IF_stall   (IF_stall),
    .PC         (PC)
`ifdef IF_FETCH_PERF_EN
    ,
    .Perf_Fetch_Cnt(perf_fetch_cnt),
    .Perf_Stall_Cnt(perf_stall_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory answers after wait_states idle cycles, or on man_ack in manual mode; data equals address.
  assign Imem_Ack  = Imem_Req && (mem_manual ? man_ack : (wait_cnt >= wait_states));
  assign Imem_Data = Imem_Addr;

  always @(posedge Clk) begin
    if (Rst || !Imem_Req || Imem_Ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] target,
                               input int cycles);
    Stall       = stall;
    Redirect    = redirect;
    Redirect_PC = target;
    repeat (cycles) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic waitRequest(input bit match_addr, input logic [31:0] addr, input bit first_cycle,
                             input string tag);
    int n = 0;
    bit found = 1'b0;
    while (!found && n < 100) begin
      @(negedge Clk);
      if (!Rst && Imem_Req && !Imem_Ack && (!first_cycle || wait_cnt == 0) &&
          (!match_addr || Imem_Addr == addr))
        found = 1'b1;
      n++;
    end
    checkOutput(tag, {31'd0, found}, 32'd1);
    @(posedge Clk);
    #1;
  endtask

  // Per-cycle model: tracks the expected PC, the buffered word and outstanding requests.
  always @(negedge Clk) begin
    logic [63:0] entry;
    bit          discard;
    if (Rst) begin
      checkOutput("req_in_reset", {31'd0, Imem_Req}, 32'd0);
      sb_q.delete();
      exp_pc    = RESET_PC;
      drop_flag = 1'b0;
      prev_out  = 1'b0;
      prev_addr = 32'd0;
    end else begin
      checkOutput("pc", PC, exp_pc);
      checkOutput("if_flush", {31'd0, IF_Flush}, {31'd0, Redirect});
      checkOutput("if_stall", {31'd0, IF_stall}, {31'd0, (Stall || sb_q.size() == 0)});
      if (sb_q.size() == 0) checkOutput("inst_empty", Inst, NOP_INST);

      if (prev_out) begin
        checkOutput("req_held", {31'd0, Imem_Req}, 32'd1);
        checkOutput("addr_held", Imem_Addr, prev_addr);
      end else begin
        if (Redirect) checkOutput("no_launch_redirect", {31'd0, Imem_Req}, 32'd0);
        if (sb_q.size() != 0 && Stall) checkOutput("no_launch_full", {31'd0, Imem_Req}, 32'd0);
      end

      if (sb_q.size() != 0 && !Stall && !Redirect) begin
        entry = sb_q.pop_front();
        checkOutput("inst", Inst, entry[63:32]);
        checkOutput("pc_4", PC_4, entry[31:0]);
      end

      if (Imem_Req && Imem_Ack) begin
        discard = Redirect || drop_flag;
        if (!discard) begin
          checkOutput("fetch_addr", Imem_Addr, exp_pc);
          sb_q.push_back({Imem_Data, exp_pc + 32'd4});
          exp_pc = exp_pc + 32'd4;
        end
        drop_flag = 1'b0;
      end

      if (Redirect) begin
        sb_q.delete();
        if (Imem_Req && !Imem_Ack) drop_flag = 1'b1;
        exp_pc = {Redirect_PC[31:2], 2'b00};
      end

      prev_out  = Imem_Req && !Imem_Ack;
      prev_addr = Imem_Addr;
    end
  end

  initial begin
    Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; Redirect_PC = 32'd0;
    wait_states = 0; mem_manual = 1'b0; man_ack = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Zero-wait streaming straight out of reset
    @(negedge Clk);
    checkOutput("rst_inst", Inst, NOP_INST);
    checkOutput("rst_pc_4", PC_4, 32'd0);
    checkOutput("rst_pc", PC, RESET_PC);
    checkOutput("t1_req0", {31'd0, Imem_Req}, 32'd1);
    checkOutput("t1_addr0", Imem_Addr, 32'h0040_0000);
    checkOutput("rst_if_stall", {31'd0, IF_stall}, 32'd1);
    @(negedge Clk);
    checkOutput("t1_addr1", Imem_Addr, 32'h0040_0004);
    checkOutput("t1_inst1", Inst, 32'h0040_0000);
    checkOutput("t1_pc4_1", PC_4, 32'h0040_0004);
    checkOutput("t1_stall1", {31'd0, IF_stall}, 32'd0);
    @(negedge Clk);
    checkOutput("t1_addr2", Imem_Addr, 32'h0040_0008);
    checkOutput("t1_inst2", Inst, 32'h0040_0004);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 3);

    // Hazard stall with the buffer full
    for (int i = 0; i < 3; i++) begin
      Stall = 1'b1;
      @(negedge Clk);
      checkOutput("t2_if_stall", {31'd0, IF_stall}, 32'd1);
      checkOutput("t2_no_req", {31'd0, Imem_Req}, 32'd0);
      @(posedge Clk); #1;
    end
    applyStimulus(1'b0, 1'b0, 32'd0, 4);

    // Two wait states from a fresh reset
    wait_states = 2;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("t3_req_a", {31'd0, Imem_Req}, 32'd1);
    checkOutput("t3_addr_a", Imem_Addr, RESET_PC);
    @(negedge Clk);
    checkOutput("t3_addr_b", Imem_Addr, RESET_PC);
    checkOutput("t3_inst_b", Inst, NOP_INST);
    @(negedge Clk);
    checkOutput("t3_req_c", {31'd0, Imem_Req}, 32'd1);
    @(negedge Clk);
    checkOutput("t3_inst", Inst, RESET_PC);
    checkOutput("t3_pc_4", PC_4, RESET_PC + 32'd4);
    checkOutput("t3_next_addr", Imem_Addr, RESET_PC + 32'd4);
    @(posedge Clk); #1;

    // Redirect while the fetch of 0x00400010 is waiting
    waitRequest(1'b1, 32'h0040_0010, 1'b1, "t4_wait");
    Redirect = 1'b1; Redirect_PC = 32'h0040_0100;
    @(negedge Clk);
    checkOutput("t4_flush", {31'd0, IF_Flush}, 32'd1);
    @(posedge Clk); #1;
    Redirect = 1'b0;
    @(negedge Clk);
    checkOutput("t4_flush_off", {31'd0, IF_Flush}, 32'd0);
    checkOutput("t4_drop_addr", Imem_Addr, 32'h0040_0010);
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("t4_new_req", {31'd0, Imem_Req}, 32'd1);
    checkOutput("t4_new_addr", Imem_Addr, 32'h0040_0100);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 8);

    // Redirect + Stall + Ack in one cycle, unaligned target
    mem_manual = 1'b1; man_ack = 1'b0;
    waitRequest(1'b0, 32'd0, 1'b0, "t5_wait");
    Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h0040_0103; man_ack = 1'b1;
    @(negedge Clk);
    checkOutput("t5_flush", {31'd0, IF_Flush}, 32'd1);
    @(posedge Clk); #1;
    Redirect = 1'b0; man_ack = 1'b0;
    @(negedge Clk);
    checkOutput("t5_pc", PC, 32'h0040_0100);
    checkOutput("t5_if_stall", {31'd0, IF_stall}, 32'd1);
    checkOutput("t5_inst", Inst, NOP_INST);
    @(posedge Clk); #1;
    mem_manual = 1'b0; wait_states = 0;
    applyStimulus(1'b0, 1'b0, 32'd0, 6);

    // Wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1);
    @(negedge Clk);
    checkOutput("t6_inst", Inst, 32'hFFFF_FFFC);
    checkOutput("t6_pc_4", PC_4, 32'h0000_0000);
    checkOutput("t6_pc", PC, 32'h0000_0000);
    @(posedge Clk); #1;

    // Reset in the middle of a wait state
    wait_states = 2;
    waitRequest(1'b0, 32'd0, 1'b1, "t6_wait");
    Rst = 1'b1;
    @(negedge Clk);
    checkOutput("t6_rst_req", {31'd0, Imem_Req}, 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    @(negedge Clk);
    checkOutput("t6_rst_pc", PC, RESET_PC);
    checkOutput("t6_rst_addr", Imem_Addr, RESET_PC);
    @(posedge Clk); #1;
    applyStimulus(1'b0, 1'b0, 32'd0, 8);

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got %0d checks expected completion", total_count);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the PC_4 / Inst / IF_Flush / IF_stall stream consumed by the IF/ID pipeline register.
- Owns the PC register and drives a req/ack instruction-memory port that may add wait states.
- Holds fetched words in a one-entry fetch buffer.
- Applies stalls from the hazard unit and branch/jump redirects from ID/EX.

Parameters:
RESET_PC, 32'h0040_0000, PC loaded on reset; bits [1:0] must be 0.
NOP_INST, 32'h0000_0000, value driven on Inst while the buffer is empty.

Ports:
Clk  in  1  clock; all state updates on posedge.
Rst  in  1  synchronous reset, active-high.
Stall  in  1  hazard-unit stall; buffered instruction must not advance.
Redirect  in  1  one-cycle pulse; taken branch/jump.
Redirect_PC  in  32  redirect target.
Imem_Req  out  1  fetch request.
Imem_Addr  out  32  fetch address; word aligned.
Imem_Ack  in  1  memory has returned data this cycle; valid only while Imem_Req=1.
Imem_Data  in  32  instruction word, valid when Imem_Ack=1.
PC_4  out  32  fetch address of buffered instruction + 4.
Inst  out  32  buffered instruction.
IF_Flush  out  1  squash IF/ID contents.
IF_stall  out  1  IF/ID must hold.
PC  out  32  next fetch address.

Behaviour:
- Reset (Rst=1 at posedge):
  - PC=RESET_PC, buffer empty, Inst=NOP_INST, PC_4=0, state FETCH.
  - Imem_Req=0 during any cycle Rst=1.
  - Rst mid-request aborts the request; memory shares the same Rst.
- Buffer and transfer:
  - Drain condition: buf_valid && !Stall && !Redirect.
  - IF_stall = Stall | !buf_valid (combinational).
  - IF_Flush = Redirect (combinational).
  - Inst/PC_4 come from buffer registers; they are constant while the buffer is full and not draining.
- States:
  - FETCH:
    - A request may launch only when the buffer is empty or draining this cycle.
    - Once Imem_Req rises it stays high with Imem_Addr=PC stable until the Ack cycle.
    - On Ack: buffer <= {Imem_Data, PC+4}, PC <= PC+4.
    - Ack with zero wait (same cycle as Req rise) is legal, giving one instruction per cycle at full throughput.
  - DROP:
    - Entered when Redirect arrives with a request outstanding and no Ack that cycle.
    - Imem_Req stays high, Imem_Addr holds the old address.
    - On Ack the data is discarded and the state returns to FETCH; the next request uses the new PC.
- Redirect:
  - Highest priority, over Stall and Ack.
  - PC <= {Redirect_PC[31:2],2'b00}; buffer emptied.
  - Redirect together with Ack in the same cycle discards the data and stays in FETCH.
  - Redirect while in DROP updates PC and stays in DROP.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- No request is launched in a cycle where Redirect=1.

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- When defined, adds outputs Perf_Fetch_Cnt[31:0] and Perf_Stall_Cnt[31:0]; both are cleared by Rst and wrap modulo 2^32.
  - Perf_Fetch_Cnt increments on each non-discarded Ack.
  - Perf_Stall_Cnt increments on each cycle with IF_stall=1.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, zero-wait memory with Data=Addr, Stall=0:
   - Imem_Addr shows 0x00400000, 0x00400004, 0x00400008 on consecutive cycles.
   - Inst=0x00400000 with PC_4=0x00400004 after the first Ack; one instruction per cycle; IF_stall=0 in steady state.
2. Stall=1 for 3 cycles with buffer full:
   - Inst/PC_4 constant, IF_stall=1, no new Req rise, PC unchanged.
   - The next instruction follows one cycle after Stall drops.
3. Memory with 2 wait states:
   - Imem_Req high 3 cycles, Imem_Addr stable, IF_stall=1 while the buffer is empty.
   - Inst updates on the Ack edge.
4. Redirect to 0x00400100 while the fetch of 0x00400010 is pending (Ack 2 cycles later):
   - IF_Flush=1 for 1 cycle; the 0x10 data is never presented.
   - The next request address is 0x00400100.
5. Redirect_PC=0x00400103 with Stall=1 and Ack in the same cycle:
   - PC=0x00400100, buffer empty, Ack data discarded, IF_stall=1 next cycle.
6. Wrap and mid-request reset:
   - Redirect to 0xFFFFFFFC then Ack gives PC_4=0x00000000 and PC=0x00000000.
   - Rst during a wait state gives Imem_Req=0 and PC=RESET_PC the next cycle.
